// File: rtl/dds_bank_mux.sv
// dds_bank_mux: time-multiplexed multi-channel DDS with shadow/active banks.
// The host fills the shadow bank through a per-field pointer, and a commit
// copies shadow to active at a frame boundary. One channel is issued per
// clock through a three-stage pipeline. The channels of a frame are summed
// and emitted as one saturated sample per frame.
module dds_bank_mux #(
  parameter int CHANNELS = 64,
  parameter int PHASE_W  = 16,
  parameter int DATA_W   = 16,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      cfg_data,
  input  logic             cfg_write,
  input  logic [1:0]       cfg_sel,
  input  logic             cfg_rewind,
  input  logic             commit,
  input  logic             commit_clear,
  input  logic             run,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             commit_pending,
  output logic             commit_done,
  output logic             cfg_wrapped
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int V_W   = DATA_W + 1;
  localparam int ACC_W = DATA_W + 1 + CH_W;
  localparam int PRD_W = 2 * DATA_W + 1;

  localparam logic [1:0] SEL_AMP  = 2'd0;
  localparam logic [1:0] SEL_OFF  = 2'd1;
  localparam logic [1:0] SEL_PW   = 2'd2;
  localparam logic [1:0] MODE_SAW = 2'd0;
  localparam logic [1:0] MODE_TRI = 2'd1;
  localparam logic [1:0] MODE_SQR = 2'd2;

  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [DATA_W-1:0] HALF    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Config word reinterpreted per field (offset is sign-extended if wider).
  logic [DATA_W-1:0]  cfg_amp;
  logic [DATA_W-1:0]  cfg_off;
  logic [PHASE_W-1:0] cfg_pw;
  assign cfg_amp = DATA_W'(cfg_data);
  assign cfg_off = DATA_W'($signed(cfg_data));
  assign cfg_pw  = PHASE_W'(cfg_data);

  logic [CH_W-1:0] chan_reg;
  logic            pending_reg;
  logic            clear_reg;
  logic            done_reg;
  logic            wrapped_reg;
  logic            copy_now;

  // The copy happens when channel 0 is issued, or on any idle cycle.
  assign copy_now = pending_reg && (!run || (chan_reg == '0));

  // ---------------------------------------------------------------------
  // Per-field write pointers
  // ---------------------------------------------------------------------
  logic [3:0][CH_W-1:0] ptr_vec;
  logic [CH_W-1:0]      cur_ptr;
  assign cur_ptr = ptr_vec[cfg_sel];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_ptr
    logic [CH_W-1:0] ptr_reg;
    // Advance on a write to this field; rewind or a copy restarts at 0.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        ptr_reg <= '0;
      else if (cfg_rewind || copy_now)
        ptr_reg <= '0;
      else if (cfg_write && (cfg_sel == 2'(gi)))
        ptr_reg <= ptr_reg + 1'b1;
    end
    assign ptr_vec[gi] = ptr_reg;
  end

  // Sticky flag set when any field pointer steps past the last channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wrapped_reg <= 1'b0;
    else if (cfg_rewind || copy_now)
      wrapped_reg <= 1'b0;
    else if (cfg_write && (cur_ptr == LAST_CH))
      wrapped_reg <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Per-channel shadow/active banks and phase accumulators
  // ---------------------------------------------------------------------
  // The *_eff views already reflect a copy happening this cycle, so the
  // channel issued on a copy cycle sees the freshly committed values.
  logic [CHANNELS-1:0][DATA_W-1:0]  amp_eff;
  logic [CHANNELS-1:0][DATA_W-1:0]  off_eff;
  logic [CHANNELS-1:0][1:0]         mode_eff;
  logic [CHANNELS-1:0][PHASE_W-1:0] phase_eff;

  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W-1:0]  sh_amp_reg, sh_off_reg, ac_amp_reg, ac_off_reg;
    logic [PHASE_W-1:0] sh_pw_reg, ac_pw_reg, phase_reg;
    logic [1:0]         sh_mode_reg, ac_mode_reg;
    logic               wr_here;
    logic               issue_here;
    logic [PHASE_W-1:0] pw_eff;
    logic [PHASE_W-1:0] phase_base;

    assign wr_here    = cfg_write && (cur_ptr == CH_W'(gi));
    assign issue_here = run && (chan_reg == CH_W'(gi));
    assign pw_eff     = copy_now ? sh_pw_reg : ac_pw_reg;
    assign phase_base = (copy_now && clear_reg) ? '0 : phase_reg;

    // Shadow bank: host writes land here one word per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sh_amp_reg  <= '0;
        sh_off_reg  <= '0;
        sh_pw_reg   <= '0;
        sh_mode_reg <= '0;
      end else if (wr_here) begin
        case (cfg_sel)
          SEL_AMP: sh_amp_reg  <= cfg_amp;
          SEL_OFF: sh_off_reg  <= cfg_off;
          SEL_PW:  sh_pw_reg   <= cfg_pw;
          default: sh_mode_reg <= cfg_data[1:0];
        endcase
      end
    end

    // Active bank: updated only by an atomic copy of the shadow bank.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ac_amp_reg  <= '0;
        ac_off_reg  <= '0;
        ac_pw_reg   <= '0;
        ac_mode_reg <= '0;
      end else if (copy_now) begin
        ac_amp_reg  <= sh_amp_reg;
        ac_off_reg  <= sh_off_reg;
        ac_pw_reg   <= sh_pw_reg;
        ac_mode_reg <= sh_mode_reg;
      end
    end

    // Phase advances once per frame when this channel issues.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        phase_reg <= '0;
      else if (issue_here)
        phase_reg <= phase_base + pw_eff;
      else
        phase_reg <= phase_base;
    end

    assign amp_eff[gi]   = copy_now ? sh_amp_reg  : ac_amp_reg;
    assign off_eff[gi]   = copy_now ? sh_off_reg  : ac_off_reg;
    assign mode_eff[gi]  = copy_now ? sh_mode_reg : ac_mode_reg;
    assign phase_eff[gi] = phase_base;
  end

  // Commit handshake: a commit arriving on a copy cycle waits for the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
      clear_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= copy_now;
      if (copy_now) begin
        pending_reg <= commit;
        clear_reg   <= commit && commit_clear;
      end else if (commit) begin
        pending_reg <= 1'b1;
        clear_reg   <= clear_reg || commit_clear;
      end
    end
  end

  // Channel index walks the frame while running and parks at 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      chan_reg <= '0;
    else if (run)
      chan_reg <= chan_reg + 1'b1;
    else
      chan_reg <= '0;
  end

  // ---------------------------------------------------------------------
  // S0: waveform lookup for the issued channel
  // ---------------------------------------------------------------------
  logic [PHASE_W-1:0] phase_sel;
  logic [DATA_W-1:0]  p_top;
  logic [DATA_W-1:0]  w_next;
  assign phase_sel = phase_eff[chan_reg];
  assign p_top     = phase_sel[PHASE_W-1 -: DATA_W];

  // Subtracting H modulo 2^DATA_W is just an MSB flip.
  always_comb begin
    w_next = '0;
    case (mode_eff[chan_reg])
      MODE_SAW: w_next = p_top ^ HALF;
      MODE_TRI: begin
        if (p_top[DATA_W-1])
          w_next = {~p_top[DATA_W-2:0], 1'b0} ^ HALF;
        else
          w_next = {p_top[DATA_W-2:0], 1'b0} ^ HALF;
      end
      MODE_SQR: w_next = p_top[DATA_W-1] ? HALF : ~HALF;
      default:  w_next = '0;
    endcase
  end

  logic              s0_valid_reg, s0_first_reg, s0_last_reg;
  logic [DATA_W-1:0] s0_w_reg, s0_amp_reg, s0_off_reg;

  // Register the waveform sample with its channel's amp and offset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_reg <= 1'b0;
      s0_first_reg <= 1'b0;
      s0_last_reg  <= 1'b0;
      s0_w_reg     <= '0;
      s0_amp_reg   <= '0;
      s0_off_reg   <= '0;
    end else begin
      s0_valid_reg <= run;
      s0_first_reg <= (chan_reg == '0);
      s0_last_reg  <= (chan_reg == LAST_CH);
      s0_w_reg     <= w_next;
      s0_amp_reg   <= amp_eff[chan_reg];
      s0_off_reg   <= off_eff[chan_reg];
    end
  end

  // ---------------------------------------------------------------------
  // S1: scale by amp and add offset
  // ---------------------------------------------------------------------
  logic signed [PRD_W-1:0] w_ext, amp_ext;
  logic signed [V_W-1:0]   prod_hi;
  logic [DATA_W-1:0]       prod_lo_unused;
  logic [V_W-1:0]          v_next;

  assign w_ext   = {{(DATA_W+1){s0_w_reg[DATA_W-1]}}, s0_w_reg};
  assign amp_ext = {{(DATA_W+1){1'b0}}, s0_amp_reg};
  // The top DATA_W+1 bits of the product are exactly product >>> DATA_W.
  assign {prod_hi, prod_lo_unused} = w_ext * amp_ext;
  assign v_next = prod_hi + {s0_off_reg[DATA_W-1], s0_off_reg};

  logic           s1_valid_reg, s1_first_reg, s1_last_reg;
  logic [V_W-1:0] s1_v_reg;

  // Register the scaled channel value and its frame markers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_v_reg     <= '0;
    end else begin
      s1_valid_reg <= s0_valid_reg;
      s1_first_reg <= s0_first_reg;
      s1_last_reg  <= s0_last_reg;
      s1_v_reg     <= v_next;
    end
  end

  // ---------------------------------------------------------------------
  // S2: frame accumulation and saturated output
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] v_ext;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    s2_last_reg;
  logic [OUT_W-1:0]        sat_next;

  assign v_ext = {{CH_W{s1_v_reg[V_W-1]}}, s1_v_reg};

  // Channel 0 restarts the sum, which also drops any aborted frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg     <= '0;
      s2_last_reg <= 1'b0;
    end else begin
      if (s1_valid_reg)
        acc_reg <= s1_first_reg ? v_ext : acc_reg + v_ext;
      s2_last_reg <= s1_valid_reg && s1_last_reg;
    end
  end

  // Clamp the frame sum into the output range.
  always_comb begin
    sat_next = acc_reg[OUT_W-1:0];
    if (acc_reg > OUT_MAX)
      sat_next = {1'b0, {(OUT_W-1){1'b1}}};
    else if (acc_reg < OUT_MIN)
      sat_next = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // Publish one sample per completed frame; hold it until the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s2_last_reg;
      if (s2_last_reg)
        sample_out <= sat_next;
    end
  end

  assign commit_pending = pending_reg;
  assign commit_done    = done_reg;
  assign cfg_wrapped    = wrapped_reg;

endmodule
